// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Fetch stage: owns the program counter, keeps at most one instruction-memory
// read in flight, and hands each returned word with its PC to the decoder over
// a valid/ready handshake. A downstream redirect restarts fetching at a new PC
// and squashes any response that belongs to the old path.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   imem_req / imem_addr     registered read request and word-aligned address
//   imem_ready               memory accepts the request this cycle
//   imem_rvalid / imem_rdata read response
//   instr_valid / instr      fetched instruction presented to decode
//   opcode                   instr[6:0], wired straight to the decoder
//   pc / pc_plus4            address of instr and that address + 4
//   instr_ready              decode consumes the instruction this cycle
//   redirect / redirect_target  restart fetch at the (word-aligned) target
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        squash_r, squash_s;
  logic [31:0] fetch_pc_r, fetch_pc_s;
  logic        req_r;
  logic        valid_r;
  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic [31:0] pc_plus4_r;
  logic        capture_s;
  logic [31:0] redir_pc_s;

  // Masking rather than slicing keeps every target bit in use; the low two
  // bits are simply forced to zero.
  assign redir_pc_s = redirect_target & 32'hFFFF_FFFC;

  // Next-state, squash and fetch-PC selection; redirect outranks every event.
  always_comb begin
    state_s    = state_r;
    squash_s   = squash_r;
    fetch_pc_s = fetch_pc_r;
    capture_s  = 1'b0;
    case (state_r)
      ST_REQ: begin
        // req_r is low for one cycle after reset, so no accept can happen then.
        if (redirect) begin
          fetch_pc_s = redir_pc_s;
          if (req_r && imem_ready) begin
            // The old address was accepted; its response must be dropped.
            squash_s = 1'b1;
            state_s  = ST_WAIT;
          end else begin
            state_s = ST_REQ;
          end
        end else if (req_r && imem_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_pc_s = redir_pc_s;
          if (imem_rvalid) begin
            squash_s = 1'b0;
            state_s  = ST_REQ;
          end else begin
            squash_s = 1'b1;
            state_s  = ST_WAIT;
          end
        end else if (imem_rvalid) begin
          if (squash_r) begin
            squash_s = 1'b0;
            state_s  = ST_REQ;
          end else begin
            capture_s = 1'b1;
            state_s   = ST_HOLD;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          fetch_pc_s = redir_pc_s;
          state_s    = ST_REQ;
        end else if (instr_ready) begin
          fetch_pc_s = pc_plus4_r;
          state_s    = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s  = ST_REQ;
        squash_s = 1'b0;
      end
    endcase
  end

  // State, PC and registered output updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_REQ;
      squash_r   <= 1'b0;
      fetch_pc_r <= RESET_PC;
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
      instr_r    <= 32'h0000_0000;
      pc_r       <= RESET_PC;
      pc_plus4_r <= RESET_PC + 32'd4;
    end else begin
      state_r    <= state_s;
      squash_r   <= squash_s;
      fetch_pc_r <= fetch_pc_s;
      req_r      <= (state_s == ST_REQ);
      valid_r    <= (state_s == ST_HOLD);
      if (capture_s) begin
        instr_r    <= imem_rdata;
        pc_r       <= fetch_pc_r;
        pc_plus4_r <= fetch_pc_r + 32'd4;
      end
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = fetch_pc_r;
  assign instr_valid = valid_r;
  assign instr       = instr_r;
  assign opcode      = instr_r[6:0];
  assign pc          = pc_r;
  assign pc_plus4    = pc_plus4_r;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the processor. Holds the program counter, issues one instruction-memory read at a time, and presents the returned instruction, its PC, and its opcode field to the main decoder through a valid/ready handshake. Taken branches and jumps resolved downstream arrive as a redirect, which squashes any in-flight or held fetch and restarts fetching at the target.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  single clock for the block; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  word-aligned read address; bits [1:0] always 0.
- imem_ready  input  1  memory accepts the request this cycle when imem_req=1.
- imem_rvalid  input  1  read data valid this cycle.
- imem_rdata  input  32  returned instruction word.
- instr_valid  output  1  instr, pc, pc_plus4 and opcode are valid.
- instr  output  32  fetched instruction.
- opcode  output  7  instr[6:0]; drives the main decoder's opcode input.
- pc  output  32  address of instr.
- pc_plus4  output  32  pc + 4, modulo 2^32.
- instr_ready  input  1  decode consumes the instruction this cycle.
- redirect  input  1  restart fetch at redirect_target.
- redirect_target  input  32  new PC; bits [1:0] are ignored and forced to 0.

## Operation

- FSM states:
  - REQ: imem_req=1, imem_addr=fetch_pc.
  - WAIT: one request outstanding.
  - HOLD: instr_valid=1.
- Reset:
  - Go to REQ with fetch_pc=RESET_PC and squash=0.
  - Outputs in the reset cycle: imem_req=0, instr_valid=0, instr=0, pc=RESET_PC, pc_plus4=RESET_PC+4.
  - Reset asserted in any state, including WAIT, abandons the outstanding request. The next imem_rvalid is not squashed; the memory must be reset in the same cycle.
- REQ transitions:
  - imem_ready=1: go to WAIT.
  - imem_ready=0: stay in REQ.
- WAIT transitions:
  - imem_rvalid=1 and squash=0: capture imem_rdata into instr, and fetch_pc into pc; go to HOLD.
  - imem_rvalid=1 and squash=1: discard the data, clear squash, go to REQ.
- HOLD transitions:
  - instr_ready=1: fetch_pc <= pc+4; go to REQ.
  - instr_ready=0: outputs stay frozen.
- Redirect has priority over every other event. Let T = {redirect_target[31:2], 2'b00}.
  - REQ with imem_ready=0: fetch_pc <= T; stay in REQ. An unaccepted address may change.
  - REQ with imem_ready=1: the old address is accepted. fetch_pc <= T, squash <= 1, go to WAIT.
  - WAIT with imem_rvalid=0: fetch_pc <= T, squash <= 1.
  - WAIT with imem_rvalid=1: drop the data, fetch_pc <= T, squash <= 0, go to REQ.
  - HOLD, regardless of instr_ready: drop the instruction, fetch_pc <= T, go to REQ. instr_valid=0 next cycle.
  - A redirect while squash=1 only updates fetch_pc.
- imem_rvalid outside WAIT is ignored.
- Only one request is ever outstanding.
- PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 32'h0.

## Timing

- Request to memory:
  - imem_req and imem_addr are registered.
  - While imem_req=1, imem_addr holds stable until imem_ready=1, except on redirect.
- Fetch latency: from cycle N with imem_ready=1 and rvalid at N+k (k≥1), instr_valid rises at N+k+1.
- Handshake:
  - The instruction transfers on the edge where instr_valid=1 and instr_ready=1.
  - instr_valid never drops without a transfer or a redirect.
- Throughput: with a 1-cycle memory, at best one instruction every 3 cycles (REQ, WAIT, HOLD).
- Redirect: the first imem_req to T appears the cycle after redirect. If a squashed response is outstanding, it appears the cycle after that response arrives.
- opcode is a wire copy of instr[6:0]. The decoder sees it combinationally in HOLD.

## Test plan

- Reset, then a 1-cycle memory returning 32'h0000_0033 at address 0 with instr_ready tied 1:
  - imem_addr=0.
  - instr_valid one cycle after rvalid, with opcode=7'd51, pc=0, pc_plus4=4.
  - Next request to address 4.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD.
  - instr, pc and instr_valid stay stable.
  - imem_req stays 0.
  - On instr_ready=1, the next request goes to pc+4.
- imem_ready=0 for 3 cycles in REQ: imem_addr and imem_req stay stable; WAIT is entered only on the accept cycle.
- Redirect to 32'h0000_0103 while in WAIT, with the stale response 32'h0000_0063 arriving 2 cycles later:
  - The stale response is dropped and instr_valid stays 0.
  - The next imem_addr is 32'h0000_0100.
  - The delivered pc is 32'h100.
- Redirect coincident with the HOLD transfer (instr_ready=1) to 32'h200: the instruction is dropped and the next fetch is 32'h200, not pc+4.
- RESET_PC=32'hFFFF_FFFC: pc_plus4=0 and the second fetch address is 0. Also assert rst during WAIT: the next cycle shows REQ at RESET_PC with instr_valid=0.
